// File: rtl/div_sequencer_if.sv
// Handshake and operand/result bundle between the EX stage and the divide sequencer.
interface div_sequencer_if #(
    parameter int BUS_WIDTH = 64
);
    logic                 start;
    logic                 flush;
    logic                 op_signed;
    logic                 op_rem;
    logic [BUS_WIDTH-1:0] dividend;
    logic [BUS_WIDTH-1:0] divisor;
    logic                 busy;
    logic                 done;
    logic [BUS_WIDTH-1:0] result;

    modport master (
        output start, flush, op_signed, op_rem, dividend, divisor,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op_signed, op_rem, dividend, divisor,
        output busy, done, result
    );
endinterface

// File: rtl/div_sequencer.sv
// Multicycle radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU; drives the EX-stage stall
// through busy and returns the quotient or remainder with a one-cycle done pulse.
module div_sequencer #(
    parameter int BUS_WIDTH   = 64,
    parameter int COUNT_WIDTH = 7
) (
    input  logic            clk,
    input  logic            rst,
    div_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    localparam logic [BUS_WIDTH-1:0]   ONE     = BUS_WIDTH'(1);
    localparam logic [BUS_WIDTH-1:0]   MIN_NEG = {1'b1, {(BUS_WIDTH-1){1'b0}}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(BUS_WIDTH);

    function automatic logic [BUS_WIDTH-1:0] negate(input logic [BUS_WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]   rem_q, rem_d;
    logic [BUS_WIDTH-1:0]   quo_q, quo_d;
    logic [BUS_WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [BUS_WIDTH-1:0]   result_q, result_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic                   op_rem_q, op_rem_d;
    logic                   busy, done;

    logic                   dividend_neg, divisor_neg, div_zero, sgn_ovf;
    logic [BUS_WIDTH-1:0]   dividend_mag, divisor_mag, special_res;
    logic [BUS_WIDTH:0]     shifted, trial;

    assign dividend_neg = bus.op_signed & bus.dividend[BUS_WIDTH-1];
    assign divisor_neg  = bus.op_signed & bus.divisor[BUS_WIDTH-1];
    assign dividend_mag = dividend_neg ? negate(bus.dividend) : bus.dividend;
    assign divisor_mag  = divisor_neg  ? negate(bus.divisor)  : bus.divisor;
    assign div_zero     = (bus.divisor == '0);
    assign sgn_ovf      = bus.op_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);

    // Divide-by-zero takes precedence; both cases bypass the iteration loop.
    assign special_res  = div_zero ? (bus.op_rem ? bus.dividend : '1)
                                   : (bus.op_rem ? '0 : bus.dividend);

    // Trial subtract one bit wider than the operands so the borrow lands in the MSB.
    assign shifted = {rem_q, quo_q[BUS_WIDTH-1]};
    assign trial   = shifted - {1'b0, dvsr_q};

    always_comb begin
        // NOTE: every output of this block is given a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        op_rem_d  = op_rem_q;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = bus.start & ~bus.flush & ~rst;
                if (bus.start && !bus.flush) begin
                    op_rem_d = bus.op_rem;
                    if (div_zero || sgn_ovf) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = dividend_mag;
                        dvsr_d    = divisor_mag;
                        neg_quo_d = dividend_neg ^ divisor_neg;
                        neg_rem_d = dividend_neg;
                        cnt_d     = CNT_MAX;
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                busy = ~bus.flush;
                if (!trial[BUS_WIDTH]) begin
                    rem_d = trial[BUS_WIDTH-1:0];
                    quo_d = {quo_q[BUS_WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[BUS_WIDTH-1:0];
                    quo_d = {quo_q[BUS_WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = S_FIX;
            end
            S_FIX: begin
                busy     = ~bus.flush;
                result_d = op_rem_q ? (neg_rem_q ? negate(rem_q) : rem_q)
                                    : (neg_quo_q ? negate(quo_q) : quo_q);
                state_d  = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A squashed instruction never commits a result, whatever state it reached.
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op_rem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            op_rem_q  <= op_rem_d;
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: arithmetic reference model plus directed vectors.
module tb_div_sequencer;
    localparam int W = 64;
    localparam logic [W-1:0] MIN_NEG = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    div_sequencer_if #(.BUS_WIDTH(W)) bus ();

    div_sequencer #(.BUS_WIDTH(W), .COUNT_WIDTH(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference arithmetic straight from the RISC-V division rules.
    function automatic logic is_special(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        return (b == '0) || (s && a == MIN_NEG && b == ONES);
    endfunction

    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s, input logic r);
        longint sa, sb;
        if (b == '0) return r ? a : ONES;
        if (s && a == MIN_NEG && b == ONES) return r ? '0 : a;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return r ? W'(sa % sb) : W'(sa / sb);
        end
        return r ? a % b : a / b;
    endfunction

    // Model tracks how long the accepted operation has been running, not the RTL state machine.
    logic         m_active = 1'b0;
    int           m_age    = 0;
    int           m_lat    = 0;
    logic [W-1:0] m_pend   = '0;
    logic [W-1:0] m_res    = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_res    <= '0;
        end else if (bus.flush) begin
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (bus.start) begin
                m_active <= 1'b1;
                m_age    <= 1;
                m_pend   <= ref_div(bus.dividend, bus.divisor, bus.op_signed, bus.op_rem);
                if (is_special(bus.dividend, bus.divisor, bus.op_signed)) begin
                    m_lat <= 1;
                    m_res <= ref_div(bus.dividend, bus.divisor, bus.op_signed, bus.op_rem);
                end else begin
                    m_lat <= W + 2;
                end
            end
        end else if (m_age == m_lat) begin
            m_active <= 1'b0;
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == m_lat) m_res <= m_pend;
        end
    end

    always @(negedge clk) begin
        logic exp_busy, exp_done;
        if (!m_active)          exp_busy = bus.start & ~bus.flush & ~rst;
        else if (m_age < m_lat) exp_busy = ~bus.flush;
        else                    exp_busy = 1'b0;
        exp_done = m_active && (m_age == m_lat);
        check("busy", W'(bus.busy), W'(exp_busy));
        check("done", W'(bus.done), W'(exp_done));
        check("result", bus.result, m_res);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic r);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.op_signed = s;
        bus.op_rem    = r;
    endtask

    // Called with start already raised in cycle 0; waits for done and checks latency and value.
    task automatic wait_done(input string name, input logic [W-1:0] exp_res, input int exp_lat);
        int cyc  = 0;
        bit seen = 1'b0;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else begin
                tick();
                cyc++;
                if (cyc == 1) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check({name, " done seen"}, W'(seen), W'(1));
        check({name, " done cycle"}, W'(cyc), W'(exp_lat));
        check({name, " value"}, bus.result, exp_res);
        tick();
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic r, input logic [W-1:0] exp_res, input int exp_lat);
        tick();
        drive(a, b, s, r);
        bus.start = 1'b1;
        wait_done(name, exp_res, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int nd, first_done, second_done;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        drive('0, '0, 1'b0, 1'b0);
        repeat (2) tick();
        check("reset busy", W'(bus.busy), W'(0));
        check("reset done", W'(bus.done), W'(0));
        check("reset result", bus.result, '0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu 100/7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 66);
        run_op("remu 100/7", 64'd100, 64'd7, 1'b0, 1'b1, 64'd2, 66);
        run_op("div -7/2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem -7/2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, ONES, 66);
        run_op("div 100/-7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 66);
        run_op("rem -100/7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("divu max/16", ONES, 64'h10, 1'b0, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF, 66);
        run_op("divu min/ones", MIN_NEG, ONES, 1'b0, 1'b0, 64'd0, 66);
        run_op("rem 7/-2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 64'd1, 66);

        // Flush in cycle 20 of a DIVU, then a fresh DIVU from cycle 21.
        nd = 0;
        tick();
        drive(64'd1000, 64'd10, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        nd += int'(bus.done);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1)  bus.start = 1'b0;
            if (c == 20) bus.flush = 1'b1;
            @(negedge clk);
            nd += int'(bus.done);
            if (c == 20) check("flush busy drop", W'(bus.busy), W'(0));
        end
        tick();
        bus.flush = 1'b0;
        check("flush no done", W'(nd), W'(0));
        check("flush result held", bus.result, 64'd1);
        drive(64'd9, 64'd3, 1'b0, 1'b0);
        bus.start = 1'b1;
        wait_done("divu 9/3 after flush", 64'd3, 66);

        run_op("divu 5/0", 64'd5, 64'd0, 1'b0, 1'b0, ONES, 1);
        run_op("rem 5/0", 64'd5, 64'd0, 1'b1, 1'b1, 64'd5, 1);
        run_op("div ovf", MIN_NEG, ONES, 1'b1, 1'b0, MIN_NEG, 1);
        run_op("rem ovf", MIN_NEG, ONES, 1'b1, 1'b1, 64'd0, 1);
        run_op("divu 9/3", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 66);

        // Asynchronous reset in cycle 30 of an operation.
        tick();
        drive(64'd100, 64'd7, 1'b0, 1'b0);
        bus.start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1) bus.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("async reset busy", W'(bus.busy), W'(0));
        check("async reset done", W'(bus.done), W'(0));
        check("async reset result", bus.result, '0);
        @(negedge clk);
        #1 rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 70; c++) begin
            tick();
            @(negedge clk);
            nd += int'(bus.done);
        end
        check("no done after reset", W'(nd), W'(0));

        // Start held high through DONE: one done per operation, re-accept only in IDLE.
        tick();
        drive(64'd100, 64'd7, 1'b0, 1'b0);
        bus.start = 1'b1;
        nd = 0;
        first_done = -1;
        second_done = -1;
        for (int c = 0; c <= 140; c++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (c == 67) check("held start re-accept busy", W'(bus.busy), W'(1));
            tick();
            if (c + 1 == 68) bus.start = 1'b0;
        end
        check("held start first done", W'(first_done), W'(66));
        check("held start second done", W'(second_done), W'(133));
        check("held start done count", W'(nd), W'(2));
        check("held start result", bus.result, 64'd14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
